// File: rtl/cordic_vec_prefold.sv
// Front-end fold for CORDIC vectoring: rotates (x, y) by 180 degrees when x < 0 so
// x ends up non-negative, flags negation overflow, and buffers results in a 2-entry FIFO.
module cordic_vec_prefold #(
    parameter int WORD_WIDTH = 16,
    parameter bit SATURATE   = 1'b1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] x_in,
    input  logic [WORD_WIDTH-1:0] y_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] x_out,
    output logic [WORD_WIDTH-1:0] y_out,
    output logic [1:0]            quad,
    output logic                  sat_flag,
    input  logic                  sat_clr,
    output logic [CNT_WIDTH-1:0]  sat_cnt
);

    localparam int ENTRY_W = 2 * WORD_WIDTH + 3;
    localparam logic [WORD_WIDTH-1:0] WORD_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [WORD_WIDTH-1:0] WORD_MAX = {1'b0, {(WORD_WIDTH-1){1'b1}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic                        w_x_neg;
    logic [1:0][WORD_WIDTH-1:0]  w_op;
    logic [1:0][WORD_WIDTH-1:0]  w_fold;
    logic [1:0]                  w_ovf;
    logic                        w_flag;
    logic [ENTRY_W-1:0]          w_entry;
    logic                        w_push;
    logic                        w_pop;
    logic [1:0]                  w_count_next;

    logic [ENTRY_W-1:0]          r_mem [0:1];
    logic                        r_wr_ptr;
    logic                        r_rd_ptr;
    logic [1:0]                  r_count;
    logic                        r_in_ready;
    logic [CNT_WIDTH-1:0]        r_sat_cnt;

    assign w_x_neg = x_in[WORD_WIDTH-1];
    assign w_op[0] = x_in;
    assign w_op[1] = y_in;

    // Index 0 folds x, index 1 folds y; both negate only when x is negative.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fold
            assign w_ovf[gi]  = w_x_neg && (w_op[gi] == WORD_MIN);
            assign w_fold[gi] = !w_x_neg                   ? w_op[gi] :
                                (w_ovf[gi] && SATURATE)    ? WORD_MAX :
                                                             ({WORD_WIDTH{1'b0}} - w_op[gi]);
        end
    endgenerate

    assign w_flag  = |w_ovf;
    assign w_entry = {w_fold[0], w_fold[1], x_in[WORD_WIDTH-1], y_in[WORD_WIDTH-1], w_flag};

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != 2'd2);
        end
    end

    // Clear takes priority over a same-cycle overflow increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_push && w_flag && (r_sat_cnt != CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign {x_out, y_out, quad, sat_flag} = r_mem[r_rd_ptr];
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: doc/cordic_vec_prefold.md
# cordic_vec_prefold

Parametrised, pipelined successor to the combinational `abs` block, used at the front of the CORDIC vectoring datapath. It accepts a signed (x, y) vector and folds it into the right half-plane: x becomes |x|, and y is negated when x is negative. It reports the quadrant and flags two's-complement overflow, with a selectable saturate or wrap policy. A 2-entry output buffer with valid/ready handshakes on both sides decouples it from the iteration stages, and it keeps a saturating count of overflow events.

## Interface
- `WORD_WIDTH`, 16, width of x/y samples (two's complement), >= 4
- `SATURATE`, 1, 1 = negating the most-negative value yields max positive; 0 = wraps (result equals input)
- `CNT_WIDTH`, 8, width of overflow event counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input sample present
- `in_ready`  out  1  block can accept (registered)
- `x_in`  in  WORD_WIDTH  signed x
- `y_in`  in  WORD_WIDTH  signed y
- `out_valid`  out  1  output sample present
- `out_ready`  in  1  downstream accepts
- `x_out`  out  WORD_WIDTH  folded x, always >= 0 when SATURATE=1
- `y_out`  out  WORD_WIDTH  folded y
- `quad`  out  2  {x_in sign, y_in sign} of the original sample
- `sat_flag`  out  1  overflow occurred on x or y negation for this sample
- `sat_clr`  in  1  synchronous clear of `sat_cnt`
- `sat_cnt`  out  CNT_WIDTH  accepted samples with sat_flag=1, saturating

## Operation
- Accept on the rising edge where `in_valid && in_ready`. Transfer out on the edge where `out_valid && out_ready`.
- Fold rule for a negative x_in (MSB=1):
  - x' = -x_in and y' = -y_in (180° rotation).
- Fold rule otherwise:
  - x' = x_in and y' = y_in. Zero counts as non-negative.
- Overflow arises when the negated operand equals -2^(W-1).
  - SATURATE=1: the result is 2^(W-1)-1.
  - SATURATE=0: the result is -2^(W-1) unchanged.
  - In both modes `sat_flag`=1. The flag is set when either x or y overflows, and only when a negation is actually performed.
- Fold and quad are computed at accept time. The buffer entry stores {x', y', quad, sat_flag}.
- Buffer: 2-entry FIFO with occupancy 0/1/2. Output fields come from the head entry and are held stable while `out_valid && !out_ready`.
- `in_ready` is registered: 1 when the next-cycle occupancy is < 2.
  - A push and pop in the same cycle leave occupancy unchanged.
  - At occupancy 2 no push can occur (`in_ready`=0).
  - A pop at occupancy 2 raises `in_ready` the following cycle.
- `sat_cnt` increments on every accepted sample with sat_flag=1 and stops at 2^CNT_WIDTH-1.
  - `sat_clr` sets it to 0.
  - If `sat_clr` and an increment occur in the same cycle, the clear wins and the result is 0.
- Reset, asynchronous, any time including mid-transfer:
  - occupancy 0, `out_valid`=0, `in_ready`=0, `sat_cnt`=0.
  - `x_out`/`y_out`/`quad`/`sat_flag`=0.
  - Buffered samples are discarded.

## Timing
- Latency: a sample accepted at edge N into an empty buffer shows `out_valid`=1 after edge N, and can transfer at edge N+1.
- Throughput: 1 sample per cycle when `out_ready` is held at 1.
- After `rst` deasserts, `in_ready` rises at the first rising edge and no earlier.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- `sat_cnt` updates at the same edge the sample is accepted.

## Test plan
- WORD_WIDTH=16, x=0x0F50, y=0xFF50, out_ready=1 -> next cycle x_out=0x0F50, y_out=0xFF50, quad=01, sat_flag=0.
- x=0xFF50 (-176), y=0x0010 -> x_out=0x00B0, y_out=0xFFF0, quad=10, sat_flag=0. Also x=0x0000, y=0x8000 -> x_out=0x0000, y_out=0x8000, sat_flag=0 (no negation).
- Overflow cases:
  - x=0x8000, y=0x0001 with SATURATE=1 -> x_out=0x7FFF, y_out=0xFFFF, sat_flag=1, sat_cnt 0->1.
  - Same input with SATURATE=0 -> x_out=0x8000.
  - x=0xFFFF, y=0x8000 with SATURATE=1 -> x_out=0x0001, y_out=0x7FFF, sat_flag=1.
- Backpressure: out_ready=0 while offering 3 samples back-to-back -> the first two are accepted and `in_ready`=0 after the second accept. Head outputs stay stable. After out_ready=1, all 3 samples emerge in order, one per cycle, with no drops or duplicates.
- `sat_cnt` at 255 plus another overflow sample -> stays 255. `sat_clr` coinciding with an overflow accept -> 0.
- Assert `rst` for half a cycle with 2 samples buffered -> `out_valid` and `sat_cnt` are 0 immediately. After release, `in_ready`=1 only after the first edge, and the old samples never appear.
